// File: rtl/full_adder_bist_ctrl.sv
// rtl/full_adder_bist_ctrl.sv - exhaustive stimulus/check engine for a 1-bit full adder
//
// Walks {a,b,cin} through 0..7 (LOOPS times), holds each vector SETTLE_CYCLES
// cycles, then checks sum/cout against a golden model in a single CHECK cycle.
// Reports pass/fail, a saturating error count and the first failing vector.
//
// Optional macro FA_BIST_FAULT_INJECT_EN: adds inj_i, sampled together with
// start_i; when set, the expected sum is inverted for the whole run so a good
// adder must produce errors (checker self-test).
//
// Ports:
//   clk_i       in   rising-edge clock
//   reset_n_i   in   synchronous active-low reset
//   start_i     in   run request, honoured in IDLE/DONE only
//   inj_i       in   (macro only) invert expected sum for this run
//   a_o/b_o/cin_o out vector driven into the adder
//   sum_i/cout_i in  adder response
//   busy_o      out  high while a run is in progress
//   done_o      out  level, high in DONE until restart or reset
//   pass_o      out  valid with done_o, 1 iff no mismatch seen
//   err_cnt_o   out  mismatching CHECK cycles, saturating
//   fail_vld_o  out  a failing vector was captured this run
//   fail_vec_o  out  first failing vector {a,b,cin}
module full_adder_bist_ctrl #(
  parameter int SETTLE_CYCLES = 1,
  parameter int LOOPS         = 1,
  parameter int ERR_CNT_W     = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 start_i,
`ifdef FA_BIST_FAULT_INJECT_EN
  input  logic                 inj_i,
`endif
  output logic                 a_o,
  output logic                 b_o,
  output logic                 cin_o,
  input  logic                 sum_i,
  input  logic                 cout_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic                 fail_vld_o,
  output logic [2:0]           fail_vec_o
);

  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LOOP_W = $clog2(LOOPS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t               state;
  logic [2:0]           vec;
  logic [SET_W-1:0]     settle_cnt;
  logic [LOOP_W-1:0]    loop_cnt;
  logic                 inj_q;
  logic                 exp_sum;
  logic                 exp_cout;
  logic                 mismatch;
  logic                 last_check;
  logic [ERR_CNT_W-1:0] err_next;

  // vec is a register, so the adder operands come straight from flops; it
  // wraps to 0 on the final CHECK, which returns the operands to 0 in DONE.
  assign a_o   = vec[2];
  assign b_o   = vec[1];
  assign cin_o = vec[0];

`ifndef FA_BIST_FAULT_INJECT_EN
  assign inj_q = 1'b0;
`endif

  always_comb begin
    exp_sum    = vec[2] ^ vec[1] ^ vec[0] ^ inj_q;
    exp_cout   = (vec[2] & vec[1]) | ((vec[2] ^ vec[1]) & vec[0]);
    // Case inequality so an X/Z response is treated as a failure.
    mismatch   = (sum_i !== exp_sum) || (cout_i !== exp_cout);
    err_next   = (mismatch && (err_cnt_o != '1)) ? err_cnt_o + ERR_CNT_W'(1) : err_cnt_o;
    last_check = (vec == 3'd7) && (loop_cnt == LOOP_W'(LOOPS - 1));
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state      <= S_IDLE;
      vec        <= 3'd0;
      settle_cnt <= '0;
      loop_cnt   <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      pass_o     <= 1'b0;
      err_cnt_o  <= '0;
      fail_vld_o <= 1'b0;
      fail_vec_o <= 3'd0;
`ifdef FA_BIST_FAULT_INJECT_EN
      inj_q      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            vec        <= 3'd0;
            settle_cnt <= '0;
            loop_cnt   <= '0;
            busy_o     <= 1'b1;
            done_o     <= 1'b0;
            pass_o     <= 1'b0;
            err_cnt_o  <= '0;
            fail_vld_o <= 1'b0;
            fail_vec_o <= 3'd0;
`ifdef FA_BIST_FAULT_INJECT_EN
            inj_q      <= inj_i;
`endif
            state      <= (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
            settle_cnt <= '0;
            state      <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        S_CHECK: begin
          err_cnt_o <= err_next;
          if (mismatch && !fail_vld_o) begin
            fail_vld_o <= 1'b1;
            fail_vec_o <= vec;
          end
          vec <= vec + 3'd1;
          if (vec == 3'd7) begin
            loop_cnt <= loop_cnt + LOOP_W'(1);
          end
          if (last_check) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            pass_o <= (err_next == '0);
            state  <= S_DONE;
          end else begin
            state  <= (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
